// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I core types carried on the common data bus
package rv32i_types;

    typedef struct packed {
        logic        cdb_valid;
        logic [4:0]  rob_idx;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] data;
    } cdb_t;

endpackage

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the CDB between functional units
// Optional per-unit grant and conflict counters under CDB_ARB_PERF_CNT_EN.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    input  cdb_t               req_pkt [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ack,
    output cdb_t               cdb_out,
    output logic [IDX_W-1:0]   grant_idx
`ifdef CDB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_grant_cnt [NUM_REQ],
    output logic [31:0]        perf_conflict_cnt
`endif
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    cdb_t             cdb_q, cdb_d;

    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    cdb_t             pkt_sel;

    // Two passes: first the indices at or above the pointer, then the wrapped-around low ones.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req_valid[i] && (i >= int'(ptr_q))) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        if (rst || flush) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
    end

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = gnt_any && (gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        pkt_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i]) begin
                pkt_sel = req_pkt[i];
            end
        end
    end

    always_comb begin
        cdb_d  = '0;
        gidx_d = gidx_q;
        ptr_d  = ptr_q;
        if (gnt_any) begin
            cdb_d           = pkt_sel;
            cdb_d.cdb_valid = 1'b1;
            gidx_d          = gnt_idx;
            ptr_d           = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q  <= '0;
            gidx_q <= '0;
            ptr_q  <= '0;
        end else begin
            cdb_q  <= cdb_d;
            gidx_q <= gidx_d;
            ptr_q  <= ptr_d;
        end
    end

    assign cdb_out   = cdb_q;
    assign grant_idx = gidx_q;

`ifdef CDB_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] conflict_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            conflict_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (!flush && ($countones(req_valid) >= 2)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt    = grant_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [N-1:0] req_valid;
    cdb_t         req_pkt [N];
    logic [N-1:0] req_ack;
    cdb_t         cdb_out;
    logic [1:0]   grant_idx;
`ifdef CDB_ARB_PERF_CNT_EN
    logic [31:0]  perf_grant_cnt [N];
    logic [31:0]  perf_conflict_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    int   m_ptr;
    cdb_t m_cdb;
    int   m_gidx;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ack   (req_ack),
        .cdb_out   (cdb_out),
        .grant_idx (grant_idx)
`ifdef CDB_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt    (perf_grant_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: first requester found walking up from the pointer, modulo N.
    function automatic int model_grant();
        if (rst || flush) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ack();
        logic [N-1:0] a;
        int g;
        a = '0;
        g = model_grant();
        if (g >= 0) a[g] = 1'b1;
        return a;
    endfunction

    function automatic cdb_t mk_pkt(input int unit, input logic [31:0] data);
        cdb_t p;
        p.cdb_valid = 1'($urandom);
        p.rob_idx   = 5'($urandom);
        p.pd        = 6'(unit);
        p.rd        = 5'($urandom);
        p.data      = data;
        return p;
    endfunction

    task automatic tick();
        int g;
        g = model_grant();
        if (rst) begin
            m_ptr  = 0;
            m_cdb  = '0;
            m_gidx = 0;
        end else if (g >= 0) begin
            m_cdb           = req_pkt[g];
            m_cdb.cdb_valid = 1'b1;
            m_gidx          = g;
            m_ptr           = (g + 1) % N;
        end else begin
            m_cdb = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b1111;
        for (int u = 0; u < N; u++) req_pkt[u] = mk_pkt(u, 32'hA0 + 32'(u));
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (req_ack !== 4'b0000) begin
                mismatched++;
                $display("FAIL reset_ack cyc=%0d got=%b exp=0000", c, req_ack);
            end
            tick();
            compared++;
            if (cdb_out !== '0 || grant_idx !== 2'd0) begin
                mismatched++;
                $display("FAIL reset_out cyc=%0d cdb=%h idx=%0d exp cdb=0 idx=0", c, cdb_out, grant_idx);
            end
        end
        rst = 1'b0;
        #1;
        compared++;
        if (req_ack !== 4'b0001) begin
            mismatched++;
            $display("FAIL reset_first_ack got=%b exp=0001", req_ack);
        end
        tick();
        compared++;
        if (cdb_out.cdb_valid !== 1'b1 || cdb_out.data !== 32'hA0 || grant_idx !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_first_bcast valid=%b data=%h idx=%0d exp valid=1 data=a0 idx=0",
                     cdb_out.cdb_valid, cdb_out.data, grant_idx);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] d [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        req_valid = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            req_pkt[2] = mk_pkt(2, d[n]);
            #1;
            compared++;
            if (req_ack !== 4'b0100) begin
                mismatched++;
                $display("FAIL single_ack n=%0d got=%b exp=0100", n, req_ack);
            end
            tick();
            compared++;
            if (cdb_out.cdb_valid !== 1'b1 || cdb_out.data !== d[n] || grant_idx !== 2'd2) begin
                mismatched++;
                $display("FAIL single_bcast n=%0d valid=%b data=%h idx=%0d exp valid=1 data=%h idx=2",
                         n, cdb_out.cdb_valid, cdb_out.data, grant_idx, d[n]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_contention();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        int cnt [N];
        do_reset();
        for (int u = 0; u < N; u++) begin
            cnt[u]     = 0;
            req_pkt[u] = mk_pkt(u, 32'(u * 256));
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            logic [N-1:0] ea;
            ea = '0;
            ea[seq[c]] = 1'b1;
            #1;
            compared++;
            if (req_ack !== ea) begin
                mismatched++;
                $display("FAIL contention_ack cyc=%0d got=%b exp=%b", c, req_ack, ea);
            end
            tick();
            compared++;
            if (grant_idx !== 2'(seq[c]) || cdb_out.data !== 32'(seq[c] * 256 + cnt[seq[c]])) begin
                mismatched++;
                $display("FAIL contention_bcast cyc=%0d idx=%0d data=%h exp idx=%0d data=%h",
                         c, grant_idx, cdb_out.data, seq[c], seq[c] * 256 + cnt[seq[c]]);
            end
            cnt[seq[c]]++;
            req_pkt[seq[c]] = mk_pkt(seq[c], 32'(seq[c] * 256 + cnt[seq[c]]));
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid  = 4'b0100;
        req_pkt[2] = mk_pkt(2, 32'h2);
        tick();
        req_valid  = 4'b1001;
        req_pkt[0] = mk_pkt(0, 32'h50);
        req_pkt[3] = mk_pkt(3, 32'h53);
        #1;
        compared++;
        if (req_ack !== 4'b1000) begin
            mismatched++;
            $display("FAIL wrap_ack3 got=%b exp=1000", req_ack);
        end
        tick();
        compared++;
        if (grant_idx !== 2'd3 || cdb_out.data !== 32'h53) begin
            mismatched++;
            $display("FAIL wrap_bcast3 idx=%0d data=%h exp idx=3 data=53", grant_idx, cdb_out.data);
        end
        req_valid = 4'b0001;
        #1;
        compared++;
        if (req_ack !== 4'b0001) begin
            mismatched++;
            $display("FAIL wrap_ack0 got=%b exp=0001", req_ack);
        end
        tick();
        compared++;
        if (grant_idx !== 2'd0 || cdb_out.data !== 32'h50) begin
            mismatched++;
            $display("FAIL wrap_bcast0 idx=%0d data=%h exp idx=0 data=50", grant_idx, cdb_out.data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        req_valid  = 4'b0001;
        req_pkt[0] = mk_pkt(0, 32'h70);
        tick();
        req_valid  = 4'b0110;
        flush      = 1'b1;
        req_pkt[1] = mk_pkt(1, 32'h71);
        req_pkt[2] = mk_pkt(2, 32'h72);
        #1;
        compared++;
        if (req_ack !== 4'b0000) begin
            mismatched++;
            $display("FAIL flush_ack got=%b exp=0000", req_ack);
        end
        compared++;
        if (cdb_out.cdb_valid !== 1'b1 || cdb_out.data !== 32'h70) begin
            mismatched++;
            $display("FAIL flush_visible valid=%b data=%h exp valid=1 data=70", cdb_out.cdb_valid, cdb_out.data);
        end
        tick();
        compared++;
        if (cdb_out !== '0) begin
            mismatched++;
            $display("FAIL flush_cdb got=%h exp=0", cdb_out);
        end
        flush = 1'b0;
        #1;
        compared++;
        if (req_ack !== 4'b0010) begin
            mismatched++;
            $display("FAIL flush_ptr_kept got=%b exp=0010", req_ack);
        end
        tick();
        compared++;
        if (grant_idx !== 2'd1 || cdb_out.data !== 32'h71) begin
            mismatched++;
            $display("FAIL flush_after idx=%0d data=%h exp idx=1 data=71", grant_idx, cdb_out.data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        req_valid  = 4'b0010;
        req_pkt[1] = mk_pkt(1, 32'h91);
        #1;
        compared++;
        if (req_ack !== 4'b0010) begin
            mismatched++;
            $display("FAIL idle_ack got=%b exp=0010", req_ack);
        end
        tick();
        req_valid = '0;
        compared++;
        if (cdb_out.cdb_valid !== 1'b1 || cdb_out.data !== 32'h91) begin
            mismatched++;
            $display("FAIL idle_t1 valid=%b data=%h exp valid=1 data=91", cdb_out.cdb_valid, cdb_out.data);
        end
        tick();
        compared++;
        if (cdb_out !== '0) begin
            mismatched++;
            $display("FAIL idle_t2 got=%h exp=0", cdb_out);
        end
        req_valid  = 4'b0101;
        req_pkt[0] = mk_pkt(0, 32'h90);
        req_pkt[2] = mk_pkt(2, 32'h92);
        #1;
        compared++;
        if (req_ack !== 4'b0100) begin
            mismatched++;
            $display("FAIL idle_ptr got=%b exp=0100", req_ack);
        end
        tick();
        compared++;
        if (grant_idx !== 2'd2 || cdb_out.data !== 32'h92) begin
            mismatched++;
            $display("FAIL idle_next idx=%0d data=%h exp idx=2 data=92", grant_idx, cdb_out.data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic         pending [N];
        cdb_t         cur [N];
        int           wait_cnt [N];
        logic [N-1:0] ea;
        do_reset();
        for (int u = 0; u < N; u++) begin
            pending[u]  = 1'b0;
            wait_cnt[u] = 0;
            cur[u]      = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = (cyc >= 300 && cyc < 302);
            for (int u = 0; u < N; u++) begin
                if (rst) begin
                    pending[u]  = 1'b0;
                    wait_cnt[u] = 0;
                end else if (!pending[u] && $urandom_range(0, 9) < 6) begin
                    pending[u] = 1'b1;
                    cur[u]     = mk_pkt(u, $urandom);
                end
                req_valid[u] = pending[u];
                req_pkt[u]   = cur[u];
            end
            flush = ($urandom_range(0, 9) == 0);
            #1;
            ea = exp_ack();
            compared++;
            if (req_ack !== ea) begin
                mismatched++;
                $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, req_ack, ea);
            end
            for (int u = 0; u < N; u++) begin
                if (ea[u]) begin
                    compared++;
                    if (wait_cnt[u] > N - 1) begin
                        mismatched++;
                        $display("FAIL rnd_fair cyc=%0d unit=%0d waited=%0d max=%0d", cyc, u, wait_cnt[u], N - 1);
                    end
                    wait_cnt[u] = 0;
                end else if (pending[u] && !flush && !rst) begin
                    wait_cnt[u]++;
                end
            end
            tick();
            compared++;
            if (cdb_out !== m_cdb || grant_idx !== 2'(m_gidx)) begin
                mismatched++;
                $display("FAIL rnd_bcast cyc=%0d cdb=%h idx=%0d exp cdb=%h idx=%0d",
                         cyc, cdb_out, grant_idx, m_cdb, m_gidx);
            end
            for (int u = 0; u < N; u++) begin
                if (ea[u]) pending[u] = 1'b0;
            end
        end
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        tick();
    endtask

    initial begin
        m_ptr  = 0;
        m_cdb  = '0;
        m_gidx = 0;
        for (int u = 0; u < N; u++) req_pkt[u] = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_flush();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the out-of-order core's functional units (alu_cmp, multiplier, divider, load/store).
- Each cycle it grants at most one requester using rotating round-robin priority and returns a combinational ack; that ack is the unit's `cdb_*_ack`.
- The granted cdb_t packet is registered and broadcast to the ROB, the physical regfile and the reservation stations on the next cycle.

Parameters:
- NUM_REQ, 4, number of requesting functional units (1..8).
- IDX_W, $clog2(NUM_REQ) (1 when NUM_REQ=1), width of the grant index and priority pointer.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  branch-mispredict flush; kills the pending and the registered broadcast.
- req_valid  in  NUM_REQ  bit i: unit i holds a finished result.
- req_pkt  in  NUM_REQ x cdb_t  result packet per unit (rv32i_types cdb_t).
- req_ack  out  NUM_REQ  one-hot-or-zero grant, combinational.
- cdb_out  out  cdb_t  registered CDB broadcast.
- grant_idx  out  IDX_W  index of the unit whose packet is in cdb_out; debug only.

Behaviour:
- Reset values:
  - cdb_out = all-zero, so cdb_out.cdb_valid = 0.
  - grant_idx = 0.
  - Priority pointer ptr = 0.
  - req_ack = 0 while rst = 1, regardless of req_valid.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending, wrapping from NUM_REQ-1 to 0.
  - The first set bit g gets req_ack[g] = 1; all other ack bits are 0.
  - When flush = 1 or rst = 1, req_ack = 0.
- Handshake:
  - A unit asserts req_valid with req_pkt and holds both stable until the cycle it sees req_ack.
  - The transfer completes at the rising edge where req_valid[i] && req_ack[i].
  - In the next cycle the unit may present a new packet or drop valid.
  - The arbiter never acks a unit whose req_valid = 0.
- Output register, updated at each edge:
  - On a grant: cdb_out <= req_pkt[g] with cdb_valid forced to 1; grant_idx <= g.
  - With no grant (no requests, flush or rst): cdb_out <= all-zero.
  - cdb_out is never held across cycles: each broadcast lasts exactly 1 cycle.
- Latency: 1 cycle from ack to broadcast. Throughput: 1 packet per cycle.
- Pointer update:
  - On a grant to g, ptr <= (g == NUM_REQ-1) ? 0 : g+1.
  - With no grant, ptr is unchanged; flush does not move ptr.
  - Fairness: a continuously requesting unit waits at most NUM_REQ-1 cycles.
- Flush:
  - In the flush cycle, no ack is given and the next cdb_out is zero.
  - A packet already in cdb_out during the flush cycle is still visible that cycle; downstream discards it on flush.
- Simultaneous events:
  - rst has priority over flush, and flush over grant.
  - A new request arriving in the same cycle as a grant to another unit waits; nothing is lost.
- NUM_REQ = 1: req_ack[0] = req_valid[0] && !flush && !rst; ptr stays 0.
- Reset mid-operation: un-acked requests are abandoned; units re-request after reset.

Optional Feature:
- Macro: CDB_ARB_PERF_CNT_EN.
- With the macro defined, extra outputs are added:
  - perf_grant_cnt: NUM_REQ x 32, per-unit grant count.
  - perf_conflict_cnt: 32, counts cycles with 2 or more req_valid bits set and no flush.
  - All counters reset to 0, wrap modulo 2^32, and are not cleared by flush.
- Without the macro: these ports and registers do not exist, and the arbitration behaviour is identical.

Test Plan:
- Reset: hold rst with req_valid = 4'b1111 -> req_ack = 0 every cycle. Release rst -> first grant to unit 0; cdb_out.cdb_valid = 1 next cycle with unit 0's data.
- Single requester: unit 2 holds req_valid for 3 packets, data 0x11, 0x22, 0x33 -> acks on 3 consecutive cycles; cdb_out.data = 0x11, 0x22, 0x33 with grant_idx = 2 on each.
- Full contention: all 4 units assert valid continuously from ptr = 0 -> grants 0,1,2,3,0,1 on successive cycles; no unit waits more than 3 cycles.
- Wrap-around: ptr = 3, req_valid = 4'b1001 -> grant 3, then ptr = 0 -> grant 0.
- Flush: req_valid = 4'b0110 with flush = 1 -> req_ack = 0, next cdb_out.cdb_valid = 0, ptr unchanged. Next cycle without flush -> unit 1 acked.
- Idle after traffic: grant to unit 1 at cycle t, then req_valid = 0 -> cdb_out.cdb_valid = 1 at t+1 and 0 at t+2, cdb_out all zero, ptr = 2.
